uart_hex_parser: RTL and testbench

UART_HEX_PARSER -- requirements
Module: uart_hex_parser

---
 rtl/uart_hex_parser_if.sv | 35 +++
 rtl/uart_hex_parser.sv | 162 ++++++++++++++++
 tb/tb_uart_hex_parser.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_hex_parser_if.sv
// ---------------------------------------------------------------------------
// uart_hex_parser_if
//   Generic valid/ready stream carrying one WIDTH-bit word per handshake.
//   A word moves on every rising clock edge where valid && ready.
//
//   Signals
//     valid : producer has a word on data
//     data  : the word itself
//     ready : consumer can take the word this cycle
//
//   Modports
//     master : producer side (drives valid/data, observes ready)
//     slave  : consumer side (observes valid/data, drives ready)
// ---------------------------------------------------------------------------
interface uart_hex_parser_if #(
   parameter int WIDTH = 8
) ();

   logic             valid;
   logic [WIDTH-1:0] data;
   logic             ready;

   modport master (
      output valid,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      output ready
   );

endinterface : uart_hex_parser_if

// File: rtl/uart_hex_parser.sv
// ---------------------------------------------------------------------------
// uart_hex_parser
//   Turns a stream of received ASCII bytes into 32-bit values. A token is
//   1..MAX_DIGITS hex digits ('0'-'9', 'A'-'F', 'a'-'f') closed by CR, LF or
//   space. Empty tokens (repeated terminators, CRLF) are dropped silently.
//   A token with too many digits or an illegal character raises a one-cycle
//   err pulse, and the remainder of that token is swallowed up to the next
//   terminator.
//
//   Ports
//     clk          : single clock, rising edge
//     rst_n        : asynchronous active-low reset
//     chars        : byte stream in  (valid / data[7:0] / ready)
//     values       : value stream out (valid / data[31:0] / ready)
//     err          : one-cycle pulse when a token is rejected
//     err_overflow : cause of the last err (1 = too many digits,
//                    0 = illegal character); holds between pulses
//     value_count  : values delivered so far, wraps at 16 bits
//
//   Parameters
//     MAX_DIGITS   : maximum hex digits per token, 1..8
// ---------------------------------------------------------------------------
module uart_hex_parser #(
   parameter int MAX_DIGITS = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   uart_hex_parser_if.slave        chars,
   uart_hex_parser_if.master       values,
   output logic                    err,
   output logic                    err_overflow,
   output logic [15:0]             value_count
);

   generate
      if (MAX_DIGITS < 1 || MAX_DIGITS > 8) begin : g_bad_param
         $error("uart_hex_parser: MAX_DIGITS must be within 1..8");
      end
   endgenerate

   localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

   // ACCUM doubles as idle: an empty accumulator is simply count == 0.
   typedef enum logic [1:0] {
      S_ACCUM,
      S_HOLD,
      S_DISCARD
   } state_t;

   state_t      state;
   logic [31:0] acc;
   logic [3:0]  count;

   logic        accept;
   logic        is_digit;
   logic        is_term;
   logic [3:0]  nibble;

   // -------------------------------------------------------------------------
   // Byte classification
   // -------------------------------------------------------------------------
   // NOTE: every output of this block gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      is_digit = 1'b0;
      nibble   = 4'h0;
      if (chars.data >= 8'h30 && chars.data <= 8'h39) begin
         is_digit = 1'b1;
         nibble   = chars.data[3:0];
      end else if ((chars.data >= 8'h41 && chars.data <= 8'h46) ||
                   (chars.data >= 8'h61 && chars.data <= 8'h66)) begin
         // 'A'/'a' have low nibble 1, so +9 lands on 10.
         is_digit = 1'b1;
         nibble   = chars.data[3:0] + 4'd9;
      end
   end

   assign is_term = (chars.data == 8'h0D) ||
                    (chars.data == 8'h0A) ||
                    (chars.data == 8'h20);

   // Not ready while a value waits downstream, including the handshake cycle
   // itself, because readiness follows the registered state.
   assign chars.ready = (state != S_HOLD);
   assign accept      = chars.valid && chars.ready;

   // -------------------------------------------------------------------------
   // Parser FSM with registered outputs
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_ACCUM;
         acc          <= 32'h0;
         count        <= 4'd0;
         values.valid <= 1'b0;
         values.data  <= 32'h0;
         err          <= 1'b0;
         err_overflow <= 1'b0;
         value_count  <= 16'h0;
      end else begin
         err <= 1'b0;

         case (state)
            S_ACCUM: begin
               if (accept) begin
                  if (is_digit) begin
                     if (count < MAX_CNT) begin
                        acc   <= {acc[27:0], nibble};
                        count <= count + 4'd1;
                     end else begin
                        err          <= 1'b1;
                        err_overflow <= 1'b1;
                        acc          <= 32'h0;
                        count        <= 4'd0;
                        state        <= S_DISCARD;
                     end
                  end else if (is_term) begin
                     // Empty tokens (CRLF, repeated spaces) fall through here.
                     if (count != 4'd0) begin
                        values.data  <= acc;
                        values.valid <= 1'b1;
                        acc          <= 32'h0;
                        count        <= 4'd0;
                        state        <= S_HOLD;
                     end
                  end else begin
                     err          <= 1'b1;
                     err_overflow <= 1'b0;
                     acc          <= 32'h0;
                     count        <= 4'd0;
                     state        <= S_DISCARD;
                  end
               end
            end

            S_HOLD: begin
               if (values.ready) begin
                  values.valid <= 1'b0;
                  value_count  <= value_count + 16'd1;
                  state        <= S_ACCUM;
               end
            end

            S_DISCARD: begin
               // Swallow the rest of a rejected token; only one err per token.
               if (accept && is_term) begin
                  acc   <= 32'h0;
                  count <= 4'd0;
                  state <= S_ACCUM;
               end
            end

            default: begin
               state <= S_ACCUM;
            end
         endcase
      end
   end

endmodule : uart_hex_parser

// File: tb/tb_uart_hex_parser.sv
// ---------------------------------------------------------------------------
// tb_uart_hex_parser
//   Self-checking bench for uart_hex_parser. Expected values and error pulses
//   are queued as stimulus is sent; a monitor pops and compares them as the
//   design produces them. Scenario tasks add their own inline checks.
// ---------------------------------------------------------------------------
module tb_uart_hex_parser;

   logic        clk;
   logic        rst_n;
   logic        err;
   logic        err_overflow;
   logic [15:0] value_count;

   uart_hex_parser_if #(.WIDTH(8))  chars_bus  ();
   uart_hex_parser_if #(.WIDTH(32)) values_bus ();

   uart_hex_parser #(.MAX_DIGITS(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .chars        (chars_bus.slave),
      .values       (values_bus.master),
      .err          (err),
      .err_overflow (err_overflow),
      .value_count  (value_count)
   );

   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] exp_q[$];
   bit          exp_err_q[$];
   logic [15:0] exp_count   = 16'h0;
   bit          prev_err    = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // -------------------------------------------------------------------------
   // Monitor: output handshakes and err pulses, sampled on the falling edge.
   // -------------------------------------------------------------------------
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (values_bus.valid === 1'b1 && values_bus.ready === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_value: got %h, required no output", values_bus.data);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               if (values_bus.data !== e) begin
                  miscompares++;
                  $display("FAIL out_value: got %h, required %h", values_bus.data, e);
               end
            end
         end
         if (err === 1'b1) begin
            vectors++;
            if (exp_err_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_err: err_overflow=%b, required no err", err_overflow);
            end else begin
               bit eo;
               eo = exp_err_q.pop_front();
               if (err_overflow !== eo) begin
                  miscompares++;
                  $display("FAIL err_overflow: got %b, required %b", err_overflow, eo);
               end
            end
            if (prev_err) begin
               miscompares++;
               $display("FAIL err_width: err high two cycles in a row, required one");
            end
         end
         prev_err = (err === 1'b1);
      end else begin
         prev_err = 1'b0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit hit, required completion");
      $fatal(1, "watchdog");
   end

   // -------------------------------------------------------------------------
   // Stimulus helpers
   // -------------------------------------------------------------------------
   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one byte and hold it until accepted; returns 1 time unit after
   // the accepting edge.
   task automatic send_byte(input logic [7:0] b);
      int t;
      t = 0;
      chars_bus.valid = 1'b1;
      chars_bus.data  = b;
      @(negedge clk);
      while (chars_bus.ready !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (chars_bus.ready !== 1'b1) begin
         vectors++;
         miscompares++;
         $display("FAIL in_ready_timeout: ready=%b after 200 cycles, required 1", chars_bus.ready);
      end
      @(posedge clk);
      #1;
      chars_bus.valid = 1'b0;
      chars_bus.data  = 8'($urandom_range(0, 255));
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   // -------------------------------------------------------------------------
   // Scenarios
   // -------------------------------------------------------------------------
   task automatic test_reset();
      chars_bus.valid  = 1'b0;
      chars_bus.data   = 8'h00;
      values_bus.ready = 1'b1;
      rst_n            = 1'b0;
      #12;
      vectors++;
      if ({values_bus.valid, values_bus.data, err, err_overflow, value_count, chars_bus.ready}
          !== {1'b0, 32'h0, 1'b0, 1'b0, 16'h0, 1'b1}) begin
         miscompares++;
         $display("FAIL reset_state: valid=%b value=%h err=%b ov=%b count=%h ready=%b, required 0 0 0 0 0 1",
                  values_bus.valid, values_bus.data, err, err_overflow, value_count, chars_bus.ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      wait_cycles(1);
      exp_count = 16'h0;
   endtask

   task automatic test_basic();
      exp_q.push_back(32'h0000_1A2B);
      send_str("1A2b");
      send_byte(8'h0D);
      vectors++;
      if (values_bus.valid !== 1'b1) begin
         miscompares++;
         $display("FAIL basic_latency: out_valid=%b one cycle after CR, required 1", values_bus.valid);
      end
      send_byte(8'h0A);
      vectors++;
      if (values_bus.valid !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_pulse: out_valid=%b after handshake, required 0", values_bus.valid);
      end
      wait_cycles(3);
      exp_count++;
      vectors++;
      if (value_count !== exp_count || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL basic_count: count=%h pending=%0d, required %h and 0", value_count, exp_q.size(), exp_count);
      end
   endtask

   task automatic test_hold();
      values_bus.ready = 1'b0;
      exp_q.push_back(32'h0000_001B);
      send_str("0000001B ");
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         vectors++;
         if ({values_bus.valid, chars_bus.ready, values_bus.data} !== {1'b1, 1'b0, 32'h0000_001B}) begin
            miscompares++;
            $display("FAIL hold_stable: cycle %0d valid=%b in_ready=%b value=%h, required 1 0 0000001b",
                     i, values_bus.valid, chars_bus.ready, values_bus.data);
         end
      end
      @(posedge clk);
      #1;
      values_bus.ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (chars_bus.ready !== 1'b0) begin
         miscompares++;
         $display("FAIL hold_handshake_ready: in_ready=%b in handshake cycle, required 0", chars_bus.ready);
      end
      @(posedge clk);
      #1;
      exp_count++;
      vectors++;
      if ({chars_bus.ready, values_bus.valid, value_count} !== {1'b1, 1'b0, exp_count}) begin
         miscompares++;
         $display("FAIL hold_release: in_ready=%b valid=%b count=%h, required 1 0 %h",
                  chars_bus.ready, values_bus.valid, value_count, exp_count);
      end
   endtask

   task automatic test_overflow();
      exp_err_q.push_back(1'b1);
      send_str("123456789");
      send_byte(8'h0A);
      exp_q.push_back(32'h0000_0007);
      send_str("7");
      send_byte(8'h0A);
      wait_cycles(3);
      exp_count++;
      vectors++;
      if (exp_q.size() != 0 || exp_err_q.size() != 0 || value_count !== exp_count) begin
         miscompares++;
         $display("FAIL overflow_outcome: pending values=%0d errs=%0d count=%h, required 0 0 %h",
                  exp_q.size(), exp_err_q.size(), value_count, exp_count);
      end
      vectors++;
      if (err_overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL overflow_hold: err_overflow=%b between pulses, required 1", err_overflow);
      end
   endtask

   task automatic test_illegal();
      exp_err_q.push_back(1'b0);
      exp_q.push_back(32'h0000_0005);
      send_str("12G4 5");
      send_byte(8'h0A);
      wait_cycles(3);
      exp_count++;
      vectors++;
      if (exp_q.size() != 0 || exp_err_q.size() != 0 || value_count !== exp_count) begin
         miscompares++;
         $display("FAIL illegal_outcome: pending values=%0d errs=%0d count=%h, required 0 0 %h",
                  exp_q.size(), exp_err_q.size(), value_count, exp_count);
      end
      vectors++;
      if (err_overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL illegal_hold: err_overflow=%b between pulses, required 0", err_overflow);
      end
      // Two faulty tokens back to back: one err each.
      exp_err_q.push_back(1'b0);
      exp_err_q.push_back(1'b1);
      exp_q.push_back(32'h0000_00AB);
      send_str("xZZ 999999999Q ab ");
      wait_cycles(3);
      exp_count++;
      vectors++;
      if (exp_q.size() != 0 || exp_err_q.size() != 0) begin
         miscompares++;
         $display("FAIL two_errors: pending values=%0d errs=%0d, required 0 0", exp_q.size(), exp_err_q.size());
      end
   endtask

   task automatic test_boundaries();
      // in_valid low with digit-looking data must be ignored.
      chars_bus.valid = 1'b0;
      chars_bus.data  = 8'h35;
      wait_cycles(4);
      // Empty tokens only: no output.
      send_byte(8'h20);
      send_byte(8'h20);
      send_byte(8'h0D);
      send_byte(8'h0A);
      // Exactly MAX_DIGITS digits, mixed case.
      exp_q.push_back(32'hFFFF_FFFF);
      send_str("FfFfffFF ");
      exp_q.push_back(32'h0000_0003);
      send_str("3 ");
      exp_q.push_back(32'h0089_ABCD);
      send_str("89aBcD");
      send_byte(8'h0D);
      wait_cycles(3);
      exp_count = exp_count + 16'd3;
      vectors++;
      if (exp_q.size() != 0 || value_count !== exp_count) begin
         miscompares++;
         $display("FAIL boundaries: pending=%0d count=%h, required 0 %h", exp_q.size(), value_count, exp_count);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      for (int i = 0; i < 20; i++) begin
         v = $urandom;
         exp_q.push_back(v);
         send_str($sformatf("%08h ", v));
         exp_count++;
      end
      wait_cycles(3);
      vectors++;
      if (exp_q.size() != 0 || value_count !== exp_count) begin
         miscompares++;
         $display("FAIL back_to_back: pending=%0d count=%h, required 0 %h", exp_q.size(), value_count, exp_count);
      end
   endtask

   task automatic test_wrap();
      // Jump the delivered-value counter close to its wrap point.
      force dut.value_count = 16'hFFFD;
      #1;
      release dut.value_count;
      exp_count = 16'hFFFD;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(32'h0);
         send_str("0 ");
         wait_cycles(2);
         exp_count++;
         vectors++;
         if (value_count !== exp_count) begin
            miscompares++;
            $display("FAIL wrap_count: token %0d count=%h, required %h", i, value_count, exp_count);
         end
      end
   endtask

   task automatic test_reset_hold();
      values_bus.ready = 1'b0;
      send_str("DEADBEEF ");
      vectors++;
      if ({values_bus.valid, values_bus.data} !== {1'b1, 32'hDEAD_BEEF}) begin
         miscompares++;
         $display("FAIL hold_before_reset: valid=%b value=%h, required 1 deadbeef", values_bus.valid, values_bus.data);
      end
      #1;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({values_bus.valid, values_bus.data, err, value_count} !== {1'b0, 32'h0, 1'b0, 16'h0}) begin
         miscompares++;
         $display("FAIL async_reset: valid=%b value=%h err=%b count=%h, required 0 0 0 0",
                  values_bus.valid, values_bus.data, err, value_count);
      end
      #1;
      rst_n            = 1'b1;
      values_bus.ready = 1'b1;
      exp_count        = 16'h0;
      exp_q.push_back(32'h0000_000F);
      send_byte(8'h46);
      send_byte(8'h0A);
      wait_cycles(3);
      exp_count++;
      vectors++;
      if (exp_q.size() != 0 || value_count !== exp_count) begin
         miscompares++;
         $display("FAIL after_reset: pending=%0d count=%h, required 0 %h", exp_q.size(), value_count, exp_count);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_overflow();
      test_illegal();
      test_boundaries();
      test_back_to_back();
      test_wrap();
      test_reset_hold();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_uart_hex_parser
